// File: rtl/elevador_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elevador_pkg
// Purpose  : Shared types and helpers for the 4-floor elevator controller:
//            FSM state enum, direction bit, floor code and floor masks.
// Revision : 1.0 - initial release
// ============================================================================
package elevador_pkg;

  localparam int N_ANDARES = 4;

  typedef logic [1:0] andar_t;

  typedef enum logic [1:0] {
    PARADO       = 2'd0,
    SUBINDO      = 2'd1,
    DESCENDO     = 2'd2,
    PORTA_ABERTA = 2'd3
  } estado_t;

  typedef enum logic {
    DIR_DESCE = 1'b0,
    DIR_SOBE  = 1'b1
  } dir_t;

  // One bit set for every floor strictly above floor a
  function automatic logic [N_ANDARES-1:0] mascara_acima(input andar_t a);
    logic [N_ANDARES-1:0] m;
    m = '0;
    for (int i = 0; i < N_ANDARES; i++) begin
      if (i > int'(a)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // One bit set for every floor strictly below floor a
  function automatic logic [N_ANDARES-1:0] mascara_abaixo(input andar_t a);
    logic [N_ANDARES-1:0] m;
    m = '0;
    for (int i = 0; i < N_ANDARES; i++) begin
      if (i < int'(a)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/controle_elevador_contador_tempo.sv
`default_nettype none
// ============================================================================
// Module   : contador_tempo
// Purpose  : Cycle timer with synchronous clear, count enable and a
//            terminal-count flag raised when the count equals `limite`.
// Revision : 1.0 - initial release
// ============================================================================
module contador_tempo #(
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limite,
  output logic             fim
);

  logic [WIDTH-1:0] contagem;

  // Clear wins over enable; holding both low freezes the count
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      contagem <= '0;
    end else if (enable) begin
      contagem <= contagem + WIDTH'(1);
    end
  end

  assign fim = (contagem == limite);

endmodule
`default_nettype wire

// File: rtl/controle_elevador.sv
`default_nettype none
// ============================================================================
// Module   : controle_elevador
// Purpose  : 4-floor elevator car controller. Latches call buttons, moves the
//            car with a SCAN (keep-direction) policy and times travel and
//            door with one shared timer.
// Options  : EMERGENCIA_EN - adds the `emergencia` input that freezes the
//            car (motors off, door output off, timer/state held).
// Revision : 1.0 - initial release
// ============================================================================
module controle_elevador
  import elevador_pkg::*;
#(
  parameter int T_ANDAR = 50_000_000,
  parameter int T_PORTA = 100_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef EMERGENCIA_EN
  input  logic                 emergencia,
`endif
  input  logic [N_ANDARES-1:0] botao,
  output andar_t               andar,
  output logic                 motor_sobe,
  output logic                 motor_desce,
  output logic                 porta_aberta,
  output logic [N_ANDARES-1:0] pedidos
);

  localparam int T_MAX = (T_ANDAR > T_PORTA) ? T_ANDAR : T_PORTA;
  localparam int TW    = $clog2(T_MAX);

  estado_t              estado, estado_prox;
  dir_t                 dir, dir_prox;
  andar_t               andar_prox, andar_mais, andar_menos;
  logic [N_ANDARES-1:0] req, limpa;
  logic                 tm_clear, tm_enable, tm_fim;
  logic [TW-1:0]        limite;
  logic                 congelado;

`ifdef EMERGENCIA_EN
  assign congelado = emergencia;
`else
  assign congelado = 1'b0;
`endif

  // Single timer: travel limit while moving, door limit while the door is open
  contador_tempo #(
    .WIDTH(TW)
  ) u_contador (
    .clk    (clk),
    .reset  (reset),
    .clear  (tm_clear),
    .enable (tm_enable),
    .limite (limite),
    .fim    (tm_fim)
  );

  // Next-state, floor, direction and request-clear decisions
  always_comb begin
    estado_prox = estado;
    andar_prox  = andar;
    dir_prox    = dir;
    limpa       = '0;
    tm_clear    = 1'b0;
    tm_enable   = 1'b0;
    limite      = TW'(T_ANDAR - 1);
    req         = pedidos | botao;
    andar_mais  = andar + 2'd1;
    andar_menos = andar - 2'd1;
    if (!congelado) begin
      case (estado)
        PARADO: begin
          tm_clear = 1'b1;
          if (req[andar]) begin
            estado_prox  = PORTA_ABERTA;
            limpa[andar] = 1'b1;
          end else if ((|(req & mascara_acima(andar))) &&
                       (dir == DIR_SOBE || !(|(req & mascara_abaixo(andar))))) begin
            estado_prox = SUBINDO;
            dir_prox    = DIR_SOBE;
          end else if (|(req & mascara_abaixo(andar))) begin
            estado_prox = DESCENDO;
            dir_prox    = DIR_DESCE;
          end
        end
        SUBINDO: begin
          if (andar == 2'd3) begin
            estado_prox = PARADO;
            tm_clear    = 1'b1;
          end else if (tm_fim) begin
            tm_clear   = 1'b1;
            andar_prox = andar_mais;
            if (req[andar_mais]) begin
              estado_prox       = PORTA_ABERTA;
              limpa[andar_mais] = 1'b1;
            end else if (!(|(req & mascara_acima(andar_mais)))) begin
              estado_prox = PARADO;
            end
          end else begin
            tm_enable = 1'b1;
          end
        end
        DESCENDO: begin
          if (andar == 2'd0) begin
            estado_prox = PARADO;
            tm_clear    = 1'b1;
          end else if (tm_fim) begin
            tm_clear   = 1'b1;
            andar_prox = andar_menos;
            if (req[andar_menos]) begin
              estado_prox        = PORTA_ABERTA;
              limpa[andar_menos] = 1'b1;
            end else if (!(|(req & mascara_abaixo(andar_menos)))) begin
              estado_prox = PARADO;
            end
          end else begin
            tm_enable = 1'b1;
          end
        end
        PORTA_ABERTA: begin
          limite       = TW'(T_PORTA - 1);
          // A call for the floor being served is absorbed and keeps the door open
          limpa[andar] = 1'b1;
          if (botao[andar]) begin
            tm_clear = 1'b1;
          end else if (tm_fim) begin
            tm_clear    = 1'b1;
            estado_prox = PARADO;
          end else begin
            tm_enable = 1'b1;
          end
        end
        default: begin
          estado_prox = PARADO;
          tm_clear    = 1'b1;
        end
      endcase
    end
  end

  // State, floor, direction and request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      estado  <= PARADO;
      andar   <= '0;
      dir     <= DIR_SOBE;
      pedidos <= '0;
    end else begin
      estado  <= estado_prox;
      andar   <= andar_prox;
      dir     <= dir_prox;
      pedidos <= req & ~limpa;
    end
  end

  // Registered motor/door drivers decoded from the current state
  always_ff @(posedge clk) begin
    if (reset) begin
      motor_sobe   <= 1'b0;
      motor_desce  <= 1'b0;
      porta_aberta <= 1'b0;
    end else begin
      motor_sobe   <= (estado == SUBINDO)      && !congelado;
      motor_desce  <= (estado == DESCENDO)     && !congelado;
      porta_aberta <= (estado == PORTA_ABERTA) && !congelado;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_controle_elevador.sv
`default_nettype none
// ============================================================================
// Module   : tb_controle_elevador
// Purpose  : Self-checking bench for controle_elevador (T_ANDAR=4, T_PORTA=3).
//            Vector tables drive inputs at relative cycles and push expected
//            outputs to a scoreboard that is compared on the falling edge.
// Options  : EMERGENCIA_EN - also exercises the emergency freeze.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controle_elevador;

  localparam int T_ANDAR = 4;
  localparam int T_PORTA = 3;

  typedef struct {
    string      nome;
    int         rel;
    logic       rst;
    logic       emg;
    logic [3:0] bot;
    logic [1:0] andar;
    logic       sobe;
    logic       desce;
    logic       porta;
    logic [3:0] ped;
  } vetor_t;

  typedef struct {
    string      nome;
    int         ciclo;
    logic [8:0] esp;
  } exp_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] botao = 4'b0000;
`ifdef EMERGENCIA_EN
  logic       emergencia = 1'b0;
`endif
  logic [1:0] andar;
  logic       motor_sobe, motor_desce, porta_aberta;
  logic [3:0] pedidos;
  logic [8:0] obs;

  int     cyc    = 0;
  int     checks = 0;
  int     errors = 0;
  exp_t   sb[$];
  vetor_t tab[$];

  controle_elevador #(
    .T_ANDAR(T_ANDAR),
    .T_PORTA(T_PORTA)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef EMERGENCIA_EN
    .emergencia   (emergencia),
`endif
    .botao        (botao),
    .andar        (andar),
    .motor_sobe   (motor_sobe),
    .motor_desce  (motor_desce),
    .porta_aberta (porta_aberta),
    .pedidos      (pedidos)
  );

  assign obs = {andar, motor_sobe, motor_desce, porta_aberta, pedidos};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare every expectation scheduled for this cycle on the falling edge
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].ciclo <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.ciclo != cyc) begin
        errors++;
        $display("FAIL %s: check for cycle %0d not reached in time (now %0d)", e.nome, e.ciclo, cyc);
      end else if (obs !== e.esp) begin
        errors++;
        $display("FAIL %s cycle %0d: got andar=%0d sobe=%b desce=%b porta=%b pedidos=%b, expected andar=%0d sobe=%b desce=%b porta=%b pedidos=%b",
                 e.nome, cyc, obs[8:7], obs[6], obs[5], obs[4], obs[3:0],
                 e.esp[8:7], e.esp[6], e.esp[5], e.esp[4], e.esp[3:0]);
      end
    end
  end

  task automatic espera_ate(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic espera(input string n, input logic [1:0] a, input logic s, input logic d,
                        input logic p, input logic [3:0] ped);
    exp_t e;
    e.nome  = n;
    e.ciclo = cyc;
    e.esp   = {a, s, d, p, ped};
    sb.push_back(e);
  endtask

  task automatic v(input string n, input int rel, input logic rst, input logic emg,
                   input logic [3:0] b, input logic [1:0] a, input logic s, input logic d,
                   input logic p, input logic [3:0] ped);
    vetor_t x;
    x.nome = n; x.rel = rel; x.rst = rst; x.emg = emg; x.bot = b;
    x.andar = a; x.sobe = s; x.desce = d; x.porta = p; x.ped = ped;
    tab.push_back(x);
  endtask

  // Apply the current table relative to the next cycle, then wait for it to drain
  task automatic roda_tabela();
    int base;
    base = cyc + 1;
    foreach (tab[i]) begin
      espera_ate(base + tab[i].rel);
      reset = tab[i].rst;
      botao = tab[i].bot;
`ifdef EMERGENCIA_EN
      emergencia = tab[i].emg;
`endif
      espera(tab[i].nome, tab[i].andar, tab[i].sobe, tab[i].desce, tab[i].porta, tab[i].ped);
    end
    tab.delete();
    espera_ate(cyc + 1);
  endtask

  initial begin
    int base;

    // Power-on reset for two cycles
    espera_ate(2);
    reset = 1'b0;
    espera("reset_inicial", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    espera_ate(cyc + 1);

    // Call at the idle floor: door for 3 cycles, request never latched
    v("porta_idle",  0, 0, 0, 4'b0001, 2'd0, 0, 0, 0, 4'b0000);
    v("porta_idle",  1, 0, 0, 4'b0000, 2'd0, 0, 0, 0, 4'b0000);
    v("porta_idle",  2, 0, 0, 4'b0000, 2'd0, 0, 0, 1, 4'b0000);
    v("porta_idle",  3, 0, 0, 4'b0000, 2'd0, 0, 0, 1, 4'b0000);
    v("porta_idle",  4, 0, 0, 4'b0000, 2'd0, 0, 0, 1, 4'b0000);
    v("porta_idle",  5, 0, 0, 4'b0000, 2'd0, 0, 0, 0, 4'b0000);
    roda_tabela();

    // Door restart: same-floor call while the door is open is dropped and extends it
    base = cyc + 1;
    espera_ate(base);     botao = 4'b0001;
    espera_ate(base + 1); botao = 4'b0000;
    espera_ate(base + 2); botao = 4'b0001;
    espera("reinicio_porta", 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
    espera_ate(base + 3); botao = 4'b0000;
    espera("reinicio_porta", 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
    espera_ate(base + 5);
    espera("reinicio_porta", 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
    espera_ate(base + 6);
    espera("reinicio_porta", 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
    espera_ate(base + 7);
    espera("reinicio_porta", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    espera_ate(cyc + 1);

    // Heading to 3, call for 2 after reaching 1: stop at 2, then resume to 3
    v("parada_2",  0, 0, 0, 4'b1000, 2'd0, 0, 0, 0, 4'b0000);
    v("parada_2",  1, 0, 0, 4'b0000, 2'd0, 0, 0, 0, 4'b1000);
    v("parada_2",  2, 0, 0, 4'b0000, 2'd0, 1, 0, 0, 4'b1000);
    v("parada_2",  4, 0, 0, 4'b0000, 2'd0, 1, 0, 0, 4'b1000);
    v("parada_2",  5, 0, 0, 4'b0100, 2'd1, 1, 0, 0, 4'b1000);
    v("parada_2",  6, 0, 0, 4'b0000, 2'd1, 1, 0, 0, 4'b1100);
    v("parada_2",  9, 0, 0, 4'b0000, 2'd2, 1, 0, 0, 4'b1000);
    v("parada_2", 10, 0, 0, 4'b0000, 2'd2, 0, 0, 1, 4'b1000);
    v("parada_2", 12, 0, 0, 4'b0000, 2'd2, 0, 0, 1, 4'b1000);
    v("parada_2", 13, 0, 0, 4'b0000, 2'd2, 0, 0, 0, 4'b1000);
    v("parada_2", 14, 0, 0, 4'b0000, 2'd2, 1, 0, 0, 4'b1000);
    v("parada_2", 17, 0, 0, 4'b0000, 2'd3, 1, 0, 0, 4'b0000);
    v("parada_2", 18, 0, 0, 4'b0000, 2'd3, 0, 0, 1, 4'b0000);
    v("parada_2", 20, 0, 0, 4'b0000, 2'd3, 0, 0, 1, 4'b0000);
    v("parada_2", 21, 0, 0, 4'b0000, 2'd3, 0, 0, 0, 4'b0000);
    roda_tabela();

    // From the top floor down to 0
    v("descida",  0, 0, 0, 4'b0001, 2'd3, 0, 0, 0, 4'b0000);
    v("descida",  1, 0, 0, 4'b0000, 2'd3, 0, 0, 0, 4'b0001);
    v("descida",  2, 0, 0, 4'b0000, 2'd3, 0, 1, 0, 4'b0001);
    v("descida",  5, 0, 0, 4'b0000, 2'd2, 0, 1, 0, 4'b0001);
    v("descida",  9, 0, 0, 4'b0000, 2'd1, 0, 1, 0, 4'b0001);
    v("descida", 13, 0, 0, 4'b0000, 2'd0, 0, 1, 0, 4'b0000);
    v("descida", 14, 0, 0, 4'b0000, 2'd0, 0, 0, 1, 4'b0000);
    v("descida", 16, 0, 0, 4'b0000, 2'd0, 0, 0, 1, 4'b0000);
    v("descida", 17, 0, 0, 4'b0000, 2'd0, 0, 0, 0, 4'b0000);
    roda_tabela();

    // SCAN: pedidos=1001 while going up, 3 is served before returning to 0
    v("scan",  0, 0, 0, 4'b1000, 2'd0, 0, 0, 0, 4'b0000);
    v("scan",  1, 0, 0, 4'b0000, 2'd0, 0, 0, 0, 4'b1000);
    v("scan",  2, 0, 0, 4'b0000, 2'd0, 1, 0, 0, 4'b1000);
    v("scan",  5, 0, 0, 4'b0000, 2'd1, 1, 0, 0, 4'b1000);
    v("scan",  6, 0, 0, 4'b0001, 2'd1, 1, 0, 0, 4'b1000);
    v("scan",  7, 0, 0, 4'b0000, 2'd1, 1, 0, 0, 4'b1001);
    v("scan",  9, 0, 0, 4'b0000, 2'd2, 1, 0, 0, 4'b1001);
    v("scan", 13, 0, 0, 4'b0000, 2'd3, 1, 0, 0, 4'b0001);
    v("scan", 14, 0, 0, 4'b0000, 2'd3, 0, 0, 1, 4'b0001);
    v("scan", 16, 0, 0, 4'b0000, 2'd3, 0, 0, 1, 4'b0001);
    v("scan", 17, 0, 0, 4'b0000, 2'd3, 0, 0, 0, 4'b0001);
    v("scan", 18, 0, 0, 4'b0000, 2'd3, 0, 1, 0, 4'b0001);
    v("scan", 21, 0, 0, 4'b0000, 2'd2, 0, 1, 0, 4'b0001);
    v("scan", 29, 0, 0, 4'b0000, 2'd0, 0, 1, 0, 4'b0000);
    v("scan", 30, 0, 0, 4'b0000, 2'd0, 0, 0, 1, 4'b0000);
    v("scan", 33, 0, 0, 4'b0000, 2'd0, 0, 0, 0, 4'b0000);
    roda_tabela();

    // Reset held 2 cycles while travelling up at floor 2
    v("reset_viagem",  0, 0, 0, 4'b1000, 2'd0, 0, 0, 0, 4'b0000);
    v("reset_viagem",  1, 0, 0, 4'b0000, 2'd0, 0, 0, 0, 4'b1000);
    v("reset_viagem",  9, 0, 0, 4'b0000, 2'd2, 1, 0, 0, 4'b1000);
    v("reset_viagem", 10, 1, 0, 4'b0000, 2'd2, 1, 0, 0, 4'b1000);
    v("reset_viagem", 11, 1, 0, 4'b0000, 2'd0, 0, 0, 0, 4'b0000);
    v("reset_viagem", 12, 0, 0, 4'b0000, 2'd0, 0, 0, 0, 4'b0000);
    v("reset_viagem", 14, 0, 0, 4'b0000, 2'd0, 0, 0, 0, 4'b0000);
    roda_tabela();

`ifdef EMERGENCIA_EN
    // Emergency for 5 cycles mid-travel; a call latched meanwhile is still served
    v("emergencia",  0, 0, 0, 4'b1000, 2'd0, 0, 0, 0, 4'b0000);
    v("emergencia",  1, 0, 0, 4'b0000, 2'd0, 0, 0, 0, 4'b1000);
    v("emergencia",  3, 0, 1, 4'b0000, 2'd0, 1, 0, 0, 4'b1000);
    v("emergencia",  4, 0, 1, 4'b0000, 2'd0, 0, 0, 0, 4'b1000);
    v("emergencia",  5, 0, 1, 4'b0100, 2'd0, 0, 0, 0, 4'b1000);
    v("emergencia",  6, 0, 1, 4'b0000, 2'd0, 0, 0, 0, 4'b1100);
    v("emergencia",  8, 0, 0, 4'b0000, 2'd0, 0, 0, 0, 4'b1100);
    v("emergencia",  9, 0, 0, 4'b0000, 2'd0, 1, 0, 0, 4'b1100);
    v("emergencia", 10, 0, 0, 4'b0000, 2'd1, 1, 0, 0, 4'b1100);
    v("emergencia", 14, 0, 0, 4'b0000, 2'd2, 1, 0, 0, 4'b1000);
    v("emergencia", 15, 0, 0, 4'b0000, 2'd2, 0, 0, 1, 4'b1000);
    v("emergencia", 17, 0, 0, 4'b0000, 2'd2, 0, 0, 1, 4'b1000);
    v("emergencia", 18, 0, 0, 4'b0000, 2'd2, 0, 0, 0, 4'b1000);
    v("emergencia", 19, 0, 0, 4'b0000, 2'd2, 1, 0, 0, 4'b1000);
    v("emergencia", 22, 0, 0, 4'b0000, 2'd3, 1, 0, 0, 4'b0000);
    v("emergencia", 23, 0, 0, 4'b0000, 2'd3, 0, 0, 1, 4'b0000);
    v("emergencia", 26, 0, 0, 4'b0000, 2'd3, 0, 0, 0, 4'b0000);
    roda_tabela();
`endif

    espera_ate(cyc + 3);
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard: %0d expectations never compared", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
